stream_bit_packer: RTL and testbench

//   Gathers a stream of narrow elements of parameter type T into fixed OUT_W-bit words.

---
 rtl/stream_bit_packer_if.sv | 38 +++
 rtl/stream_bit_packer.sv | 117 +++++++++++
 tb/tb_stream_bit_packer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_bit_packer_if.sv
// stream_bit_packer_if
//   Groups the input and output valid/ready streams of stream_bit_packer.
//   Parameters:
//     T      element type carried on in_data
//     OUT_W  packed output word width in bits
//   Signals:
//     in_valid/in_ready/in_data/in_last        element stream into the packer
//     out_valid/out_ready/out_data/out_last    packed word stream out of the packer
//     out_pad                                  zero pad bits at the MSB end of a last word
//   Modports:
//     slave   the packer side
//     master  the producer/consumer side wrapped around the packer
interface stream_bit_packer_if #(
  parameter type T     = bit [6:0],
  parameter int  OUT_W = 20
);
  localparam int PW = $clog2(OUT_W + 1);

  logic             in_valid;
  logic             in_ready;
  T                 in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic [PW-1:0]    out_pad;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_pad
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_pad
  );
endinterface

// File: rtl/stream_bit_packer.sv
// stream_bit_packer
//   Packs a stream of narrow elements of type T into OUT_W-bit words, LSB first,
//   with elements allowed to straddle word boundaries. A beat carrying in_last
//   switches to flush mode: remaining full words go out, then the residual bits
//   go out zero-padded with out_last set and out_pad giving the pad count.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    stream_bit_packer_if.slave (input and output valid/ready streams)
//   in_ready/out_valid/out_data/out_last/out_pad depend on registered state only.
module stream_bit_packer #(
  parameter type T     = bit [6:0],
  parameter int  OUT_W = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_bit_packer_if.slave    bus
);
  localparam int IN_W = $bits(T);
  localparam int CAP  = OUT_W + IN_W - 1;
  localparam int CW   = $clog2(CAP + 1);
  localparam int PW   = $clog2(OUT_W + 1);

  // Bit buffer: valid bits occupy [count_q-1:0], oldest bit at position 0.
  logic [CAP-1:0]   data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             flush_q, flush_d;

  logic             in_ready_s;
  logic             out_valid_s;
  logic [OUT_W-1:0] out_data_s;
  logic             out_last_s;
  logic [PW-1:0]    out_pad_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Output side decode: handshake flags and masked/padded word from current state.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    out_data_s  = {OUT_W{1'b0}};
    out_last_s  = 1'b0;
    out_pad_s   = {PW{1'b0}};
    if (flush_q) begin
      in_ready_s  = 1'b0;
      out_valid_s = (count_q != {CW{1'b0}});
    end else begin
      in_ready_s  = (count_q < CW'(OUT_W));
      out_valid_s = (count_q >= CW'(OUT_W));
    end
    // Bits beyond the fill level are stale; force them to zero (this is the pad).
    for (int i = 0; i < OUT_W; i++) begin
      if (CW'(i) < count_q) begin
        out_data_s[i] = data_q[i];
      end else begin
        out_data_s[i] = 1'b0;
      end
    end
    out_last_s = flush_q && (count_q <= CW'(OUT_W));
    if (out_last_s) begin
      out_pad_s = PW'(CW'(OUT_W) - count_q);
    end else begin
      out_pad_s = {PW{1'b0}};
    end
  end

  assign in_fire_s  = bus.in_valid && in_ready_s;
  assign out_fire_s = out_valid_s && bus.out_ready;

  // Next-state: append a beat, or retire a word. The two never fire together
  // because in_ready and out_valid are mutually exclusive by construction.
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    flush_d = flush_q;
    if (in_fire_s) begin
      data_d[count_q +: IN_W] = bus.in_data;
      count_d = count_q + CW'(IN_W);
      if (bus.in_last) begin
        flush_d = 1'b1;
      end else begin
        flush_d = flush_q;
      end
    end else if (out_fire_s) begin
      if (out_last_s) begin
        data_d  = {CAP{1'b0}};
        count_d = {CW{1'b0}};
        flush_d = 1'b0;
      end else begin
        data_d  = data_q >> OUT_W;
        count_d = count_q - CW'(OUT_W);
      end
    end else begin
      data_d  = data_q;
      count_d = count_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= {CAP{1'b0}};
      count_q <= {CW{1'b0}};
      flush_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.out_data  = out_data_s;
  assign bus.out_last  = out_last_s;
  assign bus.out_pad   = out_pad_s;
endmodule

// File: tb/tb_stream_bit_packer.sv
// tb_stream_bit_packer
//   Random and directed stimulus for stream_bit_packer (T=bit[6:0], OUT_W=20),
//   plus a second instance with OUT_W=5 for the one-beat-many-words case.
//   Expected words come from a bit-queue model and are compared by a monitor.
module tb_stream_bit_packer;
  localparam int OUT_W = 20;
  localparam int IN_W  = 7;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
    logic [4:0]       pad;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_bit_packer_if #(.T(bit [6:0]), .OUT_W(OUT_W)) bus ();
  stream_bit_packer_if #(.T(bit [6:0]), .OUT_W(5))     bus5 ();

  stream_bit_packer #(.T(bit [6:0]), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  stream_bit_packer #(.T(bit [6:0]), .OUT_W(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   bq[$];

  logic rand_ready   = 1'b0;
  logic forced_ready = 1'b1;
  logic ready_r      = 1'b1;
  assign bus.out_ready  = ready_r;
  assign bus5.out_ready = 1'b1;

  always @(posedge clk) begin
    #2;
    ready_r = rand_ready ? ($urandom_range(0, 9) < 7) : forced_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain bit queue; words are carved off its front.
  function automatic void emit(input int n, input bit last);
    exp_t e;
    e.data = '0;
    for (int i = 0; i < n; i++) e.data[i] = bq.pop_front();
    e.last = last;
    e.pad  = 5'(OUT_W - n);
    exp_q.push_back(e);
  endfunction

  function automatic void model_beat(input logic [6:0] d, input bit l);
    for (int i = 0; i < IN_W; i++) bq.push_back(d[i]);
    if (!l) begin
      while (bq.size() >= OUT_W) emit(OUT_W, 1'b0);
    end else begin
      while (bq.size() > OUT_W) emit(OUT_W, 1'b0);
      emit(bq.size(), 1'b1);
    end
  endfunction

  // Drive one beat; returns #1 after the edge on which it was accepted.
  task automatic send(input logic [6:0] d, input bit l);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck at 0 for %0d cycles", n);
    end else begin
      model_beat(d, l);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Monitor: scoreboard pops, backpressure stability and handshake exclusivity.
  logic             hold_v = 1'b0;
  logic [OUT_W-1:0] hold_data;
  logic             hold_last;
  logic [4:0]       hold_pad;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      chk("ready_valid_exclusive", 32'(bus.in_ready && bus.out_valid), 32'd0);
      if (hold_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(hold_data));
        chk("hold_last", 32'(bus.out_last), 32'(hold_last));
        chk("hold_pad", 32'(bus.out_pad), 32'(hold_pad));
      end
      if (bus.out_valid && !bus.out_ready) begin
        hold_v    = 1'b1;
        hold_data = bus.out_data;
        hold_last = bus.out_last;
        hold_pad  = bus.out_pad;
      end else begin
        hold_v = 1'b0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_data", 32'(bus.out_data), 32'(e.data));
          chk("sb_last", 32'(bus.out_last), 32'(e.last));
          chk("sb_pad", 32'(bus.out_pad), 32'(e.pad));
        end
      end
    end
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 7'h00;
    bus.in_last   = 1'b0;
    bus5.in_valid = 1'b0;
    bus5.in_data  = 7'h00;
    bus5.in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_out_pad", 32'(bus.out_pad), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three beats complete a 20-bit word with one bit left over.
    send(7'h01, 1'b0);
    send(7'h02, 1'b0);
    send(7'h03, 1'b0);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_in_ready", 32'(bus.in_ready), 32'd0);
    chk("t1_data", 32'(bus.out_data), 32'h0C101);
    chk("t1_last", 32'(bus.out_last), 32'd0);

    // Last beat flushes the 8 remaining bits, padded by 12.
    send(7'h7F, 1'b1);
    chk("t2_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_data", 32'(bus.out_data), 32'h000FE);
    chk("t2_last", 32'(bus.out_last), 32'd1);
    chk("t2_pad", 32'(bus.out_pad), 32'd12);
    @(posedge clk);
    #1;
    chk("t2_empty_valid", 32'(bus.out_valid), 32'd0);
    chk("t2_empty_ready", 32'(bus.in_ready), 32'd1);

    // Backpressure: word must hold and input must stay blocked.
    forced_ready = 1'b0;
    send(7'h01, 1'b0);
    send(7'h02, 1'b0);
    send(7'h03, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_hold_data", 32'(bus.out_data), 32'h0C101);
      chk("t3_hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    forced_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_popped_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_popped_in_ready", 32'(bus.in_ready), 32'd1);

    // OUT_W=5 instance: one 7-bit beat yields two words.
    bus5.in_valid = 1'b1;
    bus5.in_data  = 7'h55;
    bus5.in_last  = 1'b1;
    @(posedge clk);
    #1;
    bus5.in_valid = 1'b0;
    bus5.in_last  = 1'b0;
    chk("t4_w0_valid", 32'(bus5.out_valid), 32'd1);
    chk("t4_w0_in_ready", 32'(bus5.in_ready), 32'd0);
    chk("t4_w0_data", 32'(bus5.out_data), 32'h15);
    chk("t4_w0_last", 32'(bus5.out_last), 32'd0);
    @(posedge clk);
    #1;
    chk("t4_w1_valid", 32'(bus5.out_valid), 32'd1);
    chk("t4_w1_data", 32'(bus5.out_data), 32'h02);
    chk("t4_w1_last", 32'(bus5.out_last), 32'd1);
    chk("t4_w1_pad", 32'(bus5.out_pad), 32'd3);
    @(posedge clk);
    #1;
    chk("t4_done_valid", 32'(bus5.out_valid), 32'd0);
    chk("t4_done_in_ready", 32'(bus5.in_ready), 32'd1);

    // Asynchronous reset in the middle of a cycle discards partial data.
    send(7'h01, 1'b0);
    send(7'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t5_rst_data", 32'(bus.out_data), 32'd0);
    exp_q.delete();
    bq.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(7'h03, 1'b0);
    send(7'h00, 1'b0);
    send(7'h00, 1'b0);
    chk("t5_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_data", 32'(bus.out_data), 32'h00003);

    // Random packets with random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send(7'($urandom()), (b == len - 1));
      end
    end

    // Drain, bounded.
    begin
      int n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 1000) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
